// File: rtl/btn_press_classifier.sv
// btn_press_classifier: synchronises and debounces one raw push-button line,
// then classifies each debounced press as short, long, or long with auto-repeat.
// Every output is a flop; nothing combinational reaches an output from btn.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | debounced level low, waiting for a press
//   PRESSED   | debounced level high, counting towards the long threshold
//   LONG_HELD | long press reported, emitting periodic repeats while held
module btn_press_classifier #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 100_000_000,
  parameter int REPEAT_CYC   = 20_000_000,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic reset_p,
  input  logic btn,
  output logic btn_level,
  output logic btn_pe,
  output logic btn_ne,
  output logic short_p,
  output logic long_p,
  output logic rpt_p
);

  localparam int DW       = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HOLD_MAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW       = $clog2(HOLD_MAX) + 1;

  localparam logic [DW-1:0] DEB_TC  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] LONG_TC = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] RPT_TC  = HW'(REPEAT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  logic          s1;
  logic          s2;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hcnt;
  state_t        state;

  // The debounced level is about to change on this edge; the FSM reacts on the
  // same edge so that short_p lines up with btn_ne and long_p timing is exact.
  logic deb_flip;
  logic deb_rise;
  logic deb_fall;

  assign deb_flip = (s2 != btn_level) && (dcnt == DEB_TC);
  assign deb_rise = deb_flip && s2;
  assign deb_fall = deb_flip && !s2;

  // Two-flop synchroniser; the only consumer of the asynchronous btn input.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debouncer: any agreement with the current level restarts the stability count.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      dcnt      <= '0;
      btn_level <= 1'b0;
      btn_pe    <= 1'b0;
      btn_ne    <= 1'b0;
    end else begin
      btn_pe <= deb_rise;
      btn_ne <= deb_fall;
      if (s2 == btn_level) begin
        dcnt <= '0;
      end else if (dcnt == DEB_TC) begin
        btn_level <= s2;
        dcnt      <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // Press classifier; a release always takes priority over a threshold hit.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state   <= IDLE;
      hcnt    <= '0;
      short_p <= 1'b0;
      long_p  <= 1'b0;
      rpt_p   <= 1'b0;
    end else begin
      short_p <= 1'b0;
      long_p  <= 1'b0;
      rpt_p   <= 1'b0;
      case (state)
        IDLE: begin
          if (deb_rise) begin
            state <= PRESSED;
            hcnt  <= '0;
          end
        end
        PRESSED: begin
          if (deb_fall) begin
            state   <= IDLE;
            short_p <= 1'b1;
            hcnt    <= '0;
          end else if (hcnt == LONG_TC) begin
            state  <= LONG_HELD;
            long_p <= 1'b1;
            hcnt   <= '0;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        LONG_HELD: begin
          if (deb_fall) begin
            state <= IDLE;
            hcnt  <= '0;
          end else if (REPEAT_EN != 0) begin
            if (hcnt == RPT_TC) begin
              rpt_p <= 1'b1;
              hcnt  <= '0;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          hcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier: two instances share the button and reset,
// one with auto-repeat enabled and one with it disabled. Expected pulses are
// queued from a timing model when each press is driven and checked each cycle.
module tb_btn_press_classifier;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic clk = 1'b0;
  logic reset_p = 1'b1;
  logic btn = 1'b0;

  logic lvl0, pe0, ne0, sh0, lg0, rp0;
  logic lvl1, pe1, ne1, sh1, lg1, rp1;

  always #5 clk = ~clk;

  btn_press_classifier #(
    .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .REPEAT_EN(1)
  ) u_rep (
    .clk(clk), .reset_p(reset_p), .btn(btn),
    .btn_level(lvl0), .btn_pe(pe0), .btn_ne(ne0),
    .short_p(sh0), .long_p(lg0), .rpt_p(rp0)
  );

  btn_press_classifier #(
    .DEBOUNCE_CYC(D), .LONG_CYC(L), .REPEAT_CYC(R), .REPEAT_EN(0)
  ) u_norep (
    .clk(clk), .reset_p(reset_p), .btn(btn),
    .btn_level(lvl1), .btn_pe(pe1), .btn_ne(ne1),
    .short_p(sh1), .long_p(lg1), .rpt_p(rp1)
  );

  // mask bits: 0 btn_pe, 1 btn_ne, 2 short_p, 3 long_p, 4 rpt_p
  typedef struct {
    int         cyc;
    logic [4:0] mask;
  } ev_t;

  ev_t  q0[$];
  ev_t  q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic rst_q = 1'b1;
  logic lvl_m0 = 1'b0;
  logic lvl_m1 = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset_p;
  end

  // Per-cycle scoreboard check of level and all pulses for both instances.
  always @(negedge clk) begin
    logic [4:0] e0;
    logic [4:0] e1;
    logic [5:0] o0;
    logic [5:0] o1;
    ev_t ev;
    if (mon_en) begin
      e0 = '0;
      e1 = '0;
      if (q0.size() > 0 && q0[0].cyc == cyc) begin
        ev = q0.pop_front();
        e0 = ev.mask;
      end
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        ev = q1.pop_front();
        e1 = ev.mask;
      end
      if (rst_q) lvl_m0 = 1'b0;
      else if (e0[0]) lvl_m0 = 1'b1;
      else if (e0[1]) lvl_m0 = 1'b0;
      if (rst_q) lvl_m1 = 1'b0;
      else if (e1[0]) lvl_m1 = 1'b1;
      else if (e1[1]) lvl_m1 = 1'b0;
      o0 = {lvl0, rp0, lg0, sh0, ne0, pe0};
      o1 = {lvl1, rp1, lg1, sh1, ne1, pe1};
      tests++;
      assert (o0 === {lvl_m0, e0}) else begin
        fails++;
        $error("FAIL rep_outputs cyc=%0d observed=%b expected=%b", cyc, o0, {lvl_m0, e0});
      end
      tests++;
      assert (o1 === {lvl_m1, e1}) else begin
        fails++;
        $error("FAIL norep_outputs cyc=%0d observed=%b expected=%b", cyc, o1, {lvl_m1, e1});
      end
    end
  end

  task automatic push_ev(input bit to_rep, input bit to_norep, input int c, input logic [4:0] m);
    ev_t ev;
    ev.cyc  = c;
    ev.mask = m;
    if (to_rep) q0.push_back(ev);
    if (to_norep) q1.push_back(ev);
  endtask

  // btn driven high in cycle cr and low in cycle cf; each is sampled on the
  // next edge and passes D+1 further edges of synchroniser and debounce.
  task automatic push_press(input int cr, input int cf);
    int p;
    int f;
    p = cr + 2 + D;
    f = cf + 2 + D;
    push_ev(1'b1, 1'b1, p, 5'b00001);
    if (f <= p + L) begin
      push_ev(1'b1, 1'b1, f, 5'b00110);
    end else begin
      push_ev(1'b1, 1'b1, p + L, 5'b01000);
      for (int t = p + L + R; t < f; t += R) push_ev(1'b1, 1'b0, t, 5'b10000);
      push_ev(1'b1, 1'b1, f, 5'b00010);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int hold, input int gap);
    int cr;
    cr = cyc;
    push_press(cr, cr + hold);
    btn = 1'b1;
    step(hold);
    btn = 1'b0;
    step(gap);
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int cr;
    int r;
    reset_p = 1'b1;
    btn = 1'b0;
    step(3);
    chk("reset_rep", {lvl0, rp0, lg0, sh0, ne0, pe0}, 6'b0);
    chk("reset_norep", {lvl1, rp1, lg1, sh1, ne1, pe1}, 6'b0);
    reset_p = 1'b0;
    mon_en = 1'b1;
    step(2);

    // clean short press
    press(10, 14);

    // bounce: 3-cycle highs, 2-cycle lows never reach the debounce count
    for (int i = 0; i < 6; i++) begin
      btn = 1'b1;
      step(3);
      btn = 1'b0;
      step(2);
    end
    step(10);

    // long hold; the repeat that would coincide with the release is dropped
    press(60, 14);

    // release lands exactly on the long threshold, then one edge later
    press(20, 14);
    press(21, 14);

    // reset pulsed while in LONG_HELD with the button still down
    cr = cyc;
    push_ev(1'b1, 1'b1, cr + 2 + D, 5'b00001);
    push_ev(1'b1, 1'b1, cr + 2 + D + L, 5'b01000);
    btn = 1'b1;
    step(30);
    reset_p = 1'b1;
    step(1);
    r = cyc;
    chk("midhold_reset_rep", {lvl0, rp0, lg0, sh0, ne0, pe0}, 6'b0);
    chk("midhold_reset_norep", {lvl1, rp1, lg1, sh1, ne1, pe1}, 6'b0);
    reset_p = 1'b0;
    push_press(r, r + 40);
    step(40);
    btn = 1'b0;
    step(14);

    step(5);
    tests++;
    assert (q0.size() == 0) else begin
      fails++;
      $error("FAIL rep_queue_drained observed=%0d expected=0", q0.size());
    end
    tests++;
    assert (q1.size() == 0) else begin
      fails++;
      $error("FAIL norep_queue_drained observed=%0d expected=0", q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
